// File: rtl/seg7_scan_if.sv
// Register bus between the CPU store/load path and the 7-segment scan controller.
interface seg7_scan_if;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [15:0] wr_data;
  logic        rd_en;
  logic [1:0]  rd_addr;
  logic [15:0] rd_data;

  modport master (output wr_en, wr_addr, wr_data, rd_en, rd_addr, input rd_data);
  modport slave  (input wr_en, wr_addr, wr_data, rd_en, rd_addr, output rd_data);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// 4-digit 7-segment scan controller: shadowed value/ctrl registers committed at frame
// boundaries, per-slot anti-ghost blanking, registered active-low an/bcd outputs.
module seg7_lane (
  input  logic [3:0] nib,
  input  logic       dp,
  output logic [7:0] seg
);
  logic [6:0] glyph;

  always_comb begin
    glyph = 7'h7F;
    unique case (nib)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      4'hF: glyph = 7'h0E;
    endcase
  end

  assign seg = {~dp, glyph};
endmodule

module seg7_scan_ctrl #(
  parameter int SCAN_DIV = 100000,
  parameter int BLANK    = 16,
  parameter int CNT_W    = 17
) (
  input  logic         clk,
  input  logic         reset,
  seg7_scan_if.slave   bus,
  output logic [3:0]   an,
  output logic [7:0]   bcd,
  output logic         frame_tick
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 4;

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [15:0]      val_p, val_c;
  logic [7:0]       ctl_p, ctl_c;
  logic             slot_end, wrap, blank;
  logic [15:0]      rd_mux;
  logic [NUM_LANES-1:0][7:0] lane_seg;

  // Glyphs are always built from the committed copies so a frame is self-consistent.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    seg7_lane u_lane (
      .nib (val_c[g*VEC_W +: VEC_W]),
      .dp  (ctl_c[NUM_LANES+g]),
      .seg (lane_seg[g])
    );
  end

  assign slot_end = (cnt == CNT_W'(SCAN_DIV - 1));
  assign wrap     = slot_end && (idx == 2'd3);

  always_comb begin
    blank = (cnt < CNT_W'(BLANK)) || !ctl_c[idx];
    rd_mux = 16'h0000;
    unique case (bus.rd_addr)
      2'd0: rd_mux = val_p;
      2'd1: rd_mux = {8'h00, ctl_p};
      2'd2: rd_mux = {14'b0, idx};
      2'd3: rd_mux = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      idx         <= 2'd0;
      val_p       <= 16'h0000;
      val_c       <= 16'h0000;
      ctl_p       <= 8'h0F;
      ctl_c       <= 8'h0F;
      an          <= 4'b1111;
      bcd         <= 8'hFF;
      frame_tick  <= 1'b0;
      bus.rd_data <= 16'h0000;
    end else begin
      cnt        <= slot_end ? '0 : cnt + CNT_W'(1);
      if (slot_end) idx <= idx + 2'd1;
      frame_tick <= wrap;
      // Commit samples the pending registers before any same-cycle write lands.
      if (wrap) begin
        val_c <= val_p;
        ctl_c <= ctl_p;
      end
      if (bus.wr_en) begin
        if (bus.wr_addr == 2'd0) val_p <= bus.wr_data;
        if (bus.wr_addr == 2'd1) ctl_p <= bus.wr_data[7:0];
      end
      if (bus.rd_en) bus.rd_data <= rd_mux;
      an  <= blank ? 4'b1111 : ~(4'b0001 << idx);
      bcd <= blank ? 8'hFF   : lane_seg[idx];
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: cycle-count reference model, register table,
// directed frame/commit/reset sequences and randomized bus traffic.
module tb_seg7_scan_ctrl;
  localparam int SCAN_DIV = 8;
  localparam int BLANK    = 2;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] an;
  logic [7:0] bcd;
  logic       frame_tick;

  seg7_scan_if bus ();

  seg7_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .BLANK(BLANK), .CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .an         (an),
    .bcd        (bcd),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference state: t counts cycles since reset release; slot/digit follow from it.
  int          t;
  logic [15:0] pv, cv, mrd;
  logic [7:0]  pc, cc;
  logic [7:0]  seen [4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", nm, act, exp, t);
    end
  endtask

  task automatic tick(input bit r, input bit we, input logic [1:0] wa, input logic [15:0] wd,
                      input bit re, input logic [1:0] ra);
    logic [3:0] ea, one;
    logic [7:0] eb;
    logic [15:0] er;
    logic [3:0] nib;
    bit ef;
    int pos, dig;
    reset = r; bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd;
    bus.rd_en = re; bus.rd_addr = ra;
    one = 4'b0001;
    if (r) begin
      ea = 4'hF; eb = 8'hFF; ef = 1'b0; er = 16'h0;
    end else begin
      pos = t % SCAN_DIV;
      dig = (t / SCAN_DIV) % 4;
      nib = 4'((cv >> (4 * dig)) & 16'hF);
      if (pos < BLANK || !cc[dig]) begin
        ea = 4'hF; eb = 8'hFF;
      end else begin
        ea = 4'hF ^ (one << dig);
        eb = {~cc[4+dig], glyph[nib][6:0]};
      end
      ef = ((t + 1) % FRAME) == 0;
      er = mrd;
      if (re) begin
        case (ra)
          2'd0: er = pv;
          2'd1: er = {8'h00, pc};
          2'd2: er = 16'(dig);
          default: er = 16'h0;
        endcase
      end
    end
    @(posedge clk); #1;
    check("an", an, ea);
    check("bcd", bcd, eb);
    check("frame_tick", frame_tick, ef);
    check("rd_data", bus.rd_data, er);
    check("an_onehot", ($countones(~an) <= 1), 1);
    if (r) begin
      pv = 16'h0; cv = 16'h0; pc = 8'h0F; cc = 8'h0F; t = 0; mrd = 16'h0;
    end else begin
      if (ef) begin cv = pv; cc = pc; end
      if (we && wa == 2'd0) pv = wd;
      if (we && wa == 2'd1) pc = wd[7:0];
      mrd = er;
      t++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 2'd0, 16'h0, 0, 2'd0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    tick(0, 1, a, d, 0, 2'd0);
  endtask

  task automatic rd(input logic [1:0] a);
    tick(0, 0, 2'd0, 16'h0, 1, a);
  endtask

  task automatic wait_ft;
    for (int i = 0; i < FRAME + 2; i++) begin
      idle(1);
      if (frame_tick) return;
    end
    check("wait_ft_timeout", 0, 1);
  endtask

  task automatic collect;
    logic [3:0] one;
    one = 4'b0001;
    for (int d = 0; d < 4; d++) seen[d] = 8'hFF;
    for (int i = 0; i < FRAME; i++) begin
      idle(1);
      for (int d = 0; d < 4; d++)
        if (an == (4'hF ^ (one << d))) seen[d] = bcd;
    end
  endtask

  task automatic expect_frame(input string nm, input logic [7:0] d0, input logic [7:0] d1,
                              input logic [7:0] d2, input logic [7:0] d3);
    check({nm, "_d0"}, seen[0], d0);
    check({nm, "_d1"}, seen[1], d1);
    check({nm, "_d2"}, seen[2], d2);
    check({nm, "_d3"}, seen[3], d3);
  endtask

  typedef struct {
    bit          we;
    logic [1:0]  wa;
    logic [15:0] wd;
    bit          re;
    logic [1:0]  ra;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vt [12];

  initial begin
    vt[0]  = '{0, 2'd0, 16'h0000, 1, 2'd1, 16'h000F};
    vt[1]  = '{1, 2'd3, 16'h1234, 1, 2'd0, 16'h0000};
    vt[2]  = '{0, 2'd0, 16'h0000, 1, 2'd0, 16'h0000};
    vt[3]  = '{0, 2'd0, 16'h0000, 1, 2'd1, 16'h000F};
    vt[4]  = '{1, 2'd0, 16'h5A5A, 1, 2'd0, 16'h0000};
    vt[5]  = '{0, 2'd0, 16'h0000, 1, 2'd0, 16'h5A5A};
    vt[6]  = '{1, 2'd1, 16'hFFF3, 1, 2'd1, 16'h000F};
    vt[7]  = '{0, 2'd0, 16'h0000, 1, 2'd1, 16'h00F3};
    vt[8]  = '{0, 2'd0, 16'h0000, 1, 2'd3, 16'h0000};
    vt[9]  = '{1, 2'd2, 16'hFFFF, 1, 2'd0, 16'h5A5A};
    vt[10] = '{0, 2'd0, 16'h0000, 1, 2'd1, 16'h00F3};
    vt[11] = '{0, 2'd0, 16'h0000, 0, 2'd0, 16'h00F3};

    reset = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = 2'd0; bus.wr_data = 16'h0;
    bus.rd_en = 1'b0; bus.rd_addr = 2'd0;
    t = 0; pv = 0; cv = 0; pc = 8'h0F; cc = 8'h0F; mrd = 0;

    // Reset for 3 cycles, then the first slot: 2 blank cycles, then digit 0 = '0'.
    for (int i = 0; i < 3; i++) tick(1, 0, 2'd0, 16'h0, 0, 2'd0);
    idle(1); check("rst_blank1_an", an, 4'hF);
    idle(1); check("rst_blank2_bcd", bcd, 8'hFF);
    idle(1); check("slot0_an", an, 4'hE); check("slot0_bcd", bcd, 8'hC0);
    idle(28); check("ft_early", frame_tick, 0);
    idle(1);  check("ft_at_32", frame_tick, 1);

    // Register table: same-cycle read returns pre-write value; addr 2/3 writes ignored.
    foreach (vt[i]) begin
      tick(0, vt[i].we, vt[i].wa, vt[i].wd, vt[i].re, vt[i].ra);
      check($sformatf("table_rd%0d", i), bus.rd_data, vt[i].exp_rd);
    end

    // Mid-frame value write shows only after the next commit.
    wr(2'd1, 16'h000F);
    wr(2'd0, 16'h1234);
    rd(2'd0); check("rd_after_wr", bus.rd_data, 16'h1234);
    wait_ft;
    collect; expect_frame("val1234", 8'h99, 8'hB0, 8'hA4, 8'hF9);

    // Digits 1/3 disabled, decimal points on 0/2.
    wr(2'd1, 16'h0055);
    wait_ft;
    collect; expect_frame("ctrl55", 8'h19, 8'hFF, 8'h24, 8'hFF);

    // Write landing on the wrap edge is deferred by a whole frame.
    wr(2'd1, 16'h000F);
    wait_ft;
    for (int i = 0; i < FRAME && (t % FRAME) != FRAME - 1; i++) idle(1);
    wr(2'd0, 16'hABCD);
    check("wrap_ft", frame_tick, 1);
    collect; expect_frame("wrap_old", 8'h99, 8'hB0, 8'hA4, 8'hF9);
    collect; expect_frame("wrap_new", 8'hA1, 8'hC6, 8'h83, 8'h88);

    // Reset mid-frame during digit 2.
    wr(2'd0, 16'hFFFF);
    wait_ft;
    for (int i = 0; i < FRAME && !(((t / SCAN_DIV) % 4) == 2 && (t % SCAN_DIV) == 4); i++) idle(1);
    tick(1, 0, 2'd0, 16'h0, 0, 2'd0);
    check("midrst_an", an, 4'hF); check("midrst_bcd", bcd, 8'hFF);
    tick(1, 0, 2'd0, 16'h0, 0, 2'd0);
    idle(2);
    idle(1); check("postrst_an", an, 4'hE); check("postrst_bcd", bcd, 8'hC0);
    rd(2'd1); check("postrst_ctrl", bus.rd_data, 16'h000F);

    // Ignored address, index readback, zero register.
    wr(2'd3, 16'hBEEF);
    rd(2'd0); check("addr3_nochg", bus.rd_data, 16'h0000);
    for (int i = 0; i < FRAME && ((t / SCAN_DIV) % 4) != 1; i++) idle(1);
    rd(2'd2); check("idx_rd", bus.rd_data, 16'h0001);
    rd(2'd3); check("addr3_rd", bus.rd_data, 16'h0000);

    // Randomized traffic with occasional resets, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 299) == 0, ($urandom % 4) == 0, 2'($urandom), 16'($urandom),
           ($urandom % 2) == 1, 2'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule
